// File: rtl/spi_fifo_pkg.sv
// spi_fifo_pkg: shared constants and helpers for the spi_fifo_flex buffer.
//   clog2      - ceiling log2 as a constant function (clog2(1) = 0)
//   cnt_width  - width of an occupancy count able to hold 0..depth
//   ptr_width  - width of a pointer into a memory of 'depth' entries (min 1)
//   reg_out_mode_e - encoding of the REG_OUT parameter
package spi_fifo_pkg;

  typedef enum logic {
    REG_OUT_COMB = 1'b0,  // data_o read straight from memory
    REG_OUT_REG  = 1'b1   // data_o driven from a one-entry output register
  } reg_out_mode_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spi_fifo_out_reg.sv
// spi_fifo_out_reg: one-entry holding stage placed between FIFO memory and
// data_o so that the consumer sees a flop output rather than a memory read.
//   clk_i, rst_ni  - clock, async active-low reset
//   clr_i          - synchronous flush (empties the stage)
//   valid_i/data_i/ready_o - upstream side (from memory)
//   valid_o/data_o/ready_i - downstream side (to consumer)
// A word is taken from upstream whenever the stage is empty or is being
// emptied in the same cycle, so back-to-back transfers run at 1 word/cycle.
module spi_fifo_out_reg
  import spi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i
);

  logic load;

  assign ready_o = !valid_o || ready_i;
  assign load    = valid_i && ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (clr_i) begin
      valid_o <= 1'b0;
    end else if (load) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (ready_i) begin
      // popped with nothing available to refill
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_fifo_flex.sv
// spi_fifo_flex: single-clock valid/ready FIFO of any depth >= 2 (power of
// two not required), with runtime almost-full/almost-empty thresholds and an
// optional registered output stage.
// Parameters: DATA_WIDTH, BUFFER_DEPTH, REG_OUT (0 = comb read, 1 = output
//   register that is one of the BUFFER_DEPTH slots); CNT_W derived.
// Ports:
//   clk_i, rst_ni            - clock, async active-low reset
//   clr_i                    - synchronous flush (pointers, count, out reg, overflow)
//   valid_i, data_i, ready_o - write side
//   valid_o, data_o, ready_i - read side
//   elements_o               - words held (memory + output register)
//   af_thr_i, ae_thr_i       - thresholds for almost_full_o / almost_empty_o
//   overflow_o               - sticky: write offered while full
// Build option: define SPI_FIFO_OVF_EN to build the overflow detector; when
// undefined overflow_o is tied low.
//
// Handshake: a write transfers on a cycle where valid_i && ready_o, a read
// transfers on a cycle where valid_o && ready_i. ready_o and valid_o come from
// registered state only and never depend combinationally on valid_i/ready_i.
// A flush (clr_i) wins over any transfer offered in the same cycle.
module spi_fifo_flex
  import spi_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH   = 32,
  parameter int  BUFFER_DEPTH = 4,
  parameter int  REG_OUT      = 0,
  localparam int CNT_W        = cnt_width(BUFFER_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic [CNT_W-1:0]      elements_o,
  input  logic [CNT_W-1:0]      af_thr_i,
  input  logic [CNT_W-1:0]      ae_thr_i,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o
);

  localparam bit USE_REG   = (REG_OUT == int'(REG_OUT_REG));
  // With the output register fitted, it holds one of the slots.
  localparam int MEM_DEPTH = USE_REG ? BUFFER_DEPTH - 1 : BUFFER_DEPTH;
  localparam int PTR_W     = ptr_width(MEM_DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push;
  logic                  pop;
  logic                  mem_wr;
  logic                  mem_rd;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Explicit compare-and-reset keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign ready_o    = (count_q != FULL_CNT);
  assign push       = valid_i && ready_o;
  assign pop        = valid_o && ready_i;
  assign mem_wr     = push && !clr_i;
  assign mem_rdata  = mem_q[rd_ptr_q];
  assign elements_o = count_q;

  // af_thr_i = 0 and ae_thr_i >= BUFFER_DEPTH saturate naturally here.
  assign almost_full_o  = (count_q >= af_thr_i);
  assign almost_empty_o = (count_q <= ae_thr_i);

  generate
    if (USE_REG) begin : g_reg_out
      logic [CNT_W-1:0] mem_cnt;
      logic             mem_valid;
      logic             or_ready;

      // Memory occupancy is the total minus the word parked in the register.
      assign mem_cnt   = count_q - CNT_W'(valid_o);
      assign mem_valid = (mem_cnt != '0);
      assign mem_rd    = mem_valid && or_ready && !clr_i;

      spi_fifo_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_out_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .valid_i(mem_valid),
        .data_i (mem_rdata),
        .ready_o(or_ready),
        .valid_o(valid_o),
        .data_o (data_o),
        .ready_i(ready_i)
      );
    end else begin : g_comb_out
      assign valid_o = (count_q != '0);
      assign data_o  = mem_rdata;
      assign mem_rd  = pop && !clr_i;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      // memory contents are left as they are
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (mem_wr) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (mem_rd) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

`ifdef SPI_FIFO_OVF_EN
  logic ovf_q;

  // clr_i takes priority over a same-cycle overflow event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (clr_i) begin
      ovf_q <= 1'b0;
    end else if (valid_i && !ready_o) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

endmodule
